// File: rtl/fir_bitserial_mac.sv
// ============================================================================
// Module   : fir_bitserial_mac
// Purpose  : Bit-serial FIR stage with a TAPS-deep capture buffer, a snapshot
//            hold buffer and a one-tap-per-cycle multiply-accumulate.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module fir_bitserial_mac #(
    parameter int TAPS    = 8,
    parameter int COEF_W  = 8,
    parameter int ACC_W   = COEF_W + $clog2(TAPS) + 1,
    parameter int BIPOLAR = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    input  logic                     filter,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     overrun_clr,
    output logic signed [ACC_W-1:0]  result,
    output logic                     result_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int              c_AW   = $clog2(TAPS);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(TAPS - 1);
    localparam logic [c_AW:0]   c_TAPS = (c_AW + 1)'(TAPS);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]               r_state;
    logic [0:0]               w_state_nxt;
    logic [TAPS-1:0]          r_buf1;
    logic [TAPS-1:0]          r_buf2;
    logic signed [COEF_W-1:0] r_coef [TAPS];
    logic signed [ACC_W-1:0]  r_acc;
    logic [c_AW-1:0]          r_idx;
    logic signed [ACC_W-1:0]  w_coef_ext;
    logic signed [ACC_W-1:0]  w_term;
    logic signed [ACC_W-1:0]  w_sum;
    logic                     w_accept;
    logic                     w_last;
    logic                     w_coef_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (filter) w_state_nxt = c_RUN;
            c_RUN:   if (r_idx == c_LAST) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == c_RUN);
        w_accept  = (r_state == c_IDLE) && filter;
        w_last    = (r_state == c_RUN) && (r_idx == c_LAST);
        w_coef_wr = (r_state == c_IDLE) && coef_we && ({1'b0, coef_addr} < c_TAPS);
    end

    // Per-tap contribution: zero bits subtract only in bipolar mode.
    always_comb begin
        w_coef_ext = ACC_W'(r_coef[r_idx]);
        w_term     = '0;
        if (r_buf2[r_idx]) begin
            w_term = w_coef_ext;
        end else if (BIPOLAR != 0) begin
            w_term = -w_coef_ext;
        end
        w_sum = r_acc + w_term;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf1       <= '0;
            r_buf2       <= '0;
            r_acc        <= '0;
            r_idx        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else begin
            if (bit_valid) begin
                r_buf1 <= {r_buf1[TAPS-2:0], bit_in};
            end

            if (w_accept) begin
                r_buf2 <= r_buf1;
                r_acc  <= '0;
                r_idx  <= '0;
            end else if (r_state == c_RUN) begin
                r_acc <= w_sum;
                r_idx <= r_idx + 1'b1;
            end

            result_valid <= w_last;
            if (w_last) begin
                result <= w_sum;
            end

            // A new overrun on the same edge as a clear keeps the flag set.
            if ((r_state == c_RUN) && filter) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            if (w_coef_wr) begin
                r_coef[coef_addr] <= coef_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fir_bitserial_mac.sv
// ============================================================================
// Module   : tb_fir_bitserial_mac
// Purpose  : Directed vector bench for fir_bitserial_mac, unipolar and bipolar.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_bitserial_mac;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              bit_in, bit_valid, filter, coef_we, overrun_clr;
    logic [2:0]        coef_addr;
    logic signed [7:0] coef_data;
    logic signed [11:0] result_u, result_b;
    logic              result_valid_u, result_valid_b;
    logic              busy_u, busy_b, overrun_u, overrun_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fir_bitserial_mac #(.TAPS(8), .COEF_W(8), .BIPOLAR(0)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .filter(filter), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .overrun_clr(overrun_clr),
        .result(result_u), .result_valid(result_valid_u),
        .busy(busy_u), .overrun(overrun_u)
    );

    fir_bitserial_mac #(.TAPS(8), .COEF_W(8), .BIPOLAR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .filter(filter), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .overrun_clr(overrun_clr),
        .result(result_b), .result_valid(result_valid_b),
        .busy(busy_b), .overrun(overrun_b)
    );

    typedef struct {
        logic [7:0]  pat;
        logic [63:0] coefs;
        int          exp_u;
        int          exp_b;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [63:0] pk(int c0, int c1, int c2, int c3,
                                       int c4, int c5, int c6, int c7);
        return {8'(c7), 8'(c6), 8'(c5), 8'(c4), 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    task automatic check(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(int a, logic [7:0] d);
        coef_we   = 1'b1;
        coef_addr = 3'(a);
        coef_data = d;
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic load_coefs(logic [63:0] c);
        for (int i = 0; i < 8; i++) write_coef(i, c[8*i +: 8]);
    endtask

    // MSB first, so afterwards buffer bit i equals p[i].
    task automatic shift_byte(logic [7:0] p);
        for (int i = 7; i >= 0; i--) begin
            bit_valid = 1'b1;
            bit_in    = p[i];
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic wait_result(string tag, output int ru, output int rb);
        int lat = 0;
        while (!result_valid_u && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, 8);
        check({tag, "_busy_end"}, int'(busy_u), 0);
        ru = int'(result_u);
        rb = int'(result_b);
        tick();
        check({tag, "_strobe_1cyc"}, int'(result_valid_u), 0);
    endtask

    task automatic run_filter(string tag, output int ru, output int rb);
        filter = 1'b1;
        tick();
        filter = 1'b0;
        check({tag, "_busy"}, int'(busy_u), 1);
        wait_result(tag, ru, rb);
    endtask

    int ru, rb, strobes;
    logic [63:0] ramp;

    initial begin
        ramp = pk(1, 2, 3, 4, 5, 6, 7, 8);
        vecs[0] = '{8'hFF, ramp, 36, 36};
        vecs[1] = '{8'h55, ramp, 16, -4};
        vecs[2] = '{8'h00, ramp, 0, -36};
        vecs[3] = '{8'hFF, pk(-128, -128, -128, -128, -128, -128, -128, -128), -1024, -1024};
        vecs[4] = '{8'h00, pk(-128, -128, -128, -128, -128, -128, -128, -128), 0, 1024};
        vecs[5] = '{8'h0F, pk(10, -20, 30, -40, 5, 6, 7, 8), -20, -46};
        vecs[6] = '{8'h80, pk(1, 1, 1, 1, 1, 1, 1, 127), 127, 120};
        vecs[7] = '{8'h01, pk(127, 127, 127, 127, 127, 127, 127, 127), 127, -762};

        rst_n = 1'b0; bit_in = 0; bit_valid = 0; filter = 0;
        coef_we = 0; coef_addr = 0; coef_data = 0; overrun_clr = 0;
        #12;
        check("rst_result", int'(result_u), 0);
        check("rst_valid", int'(result_valid_u), 0);
        check("rst_busy", int'(busy_u), 0);
        check("rst_overrun", int'(overrun_u), 0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            load_coefs(vecs[v].coefs);
            shift_byte(vecs[v].pat);
            run_filter($sformatf("vec%0d", v), ru, rb);
            check($sformatf("vec%0d_uni", v), ru, vecs[v].exp_u);
            check($sformatf("vec%0d_bip", v), rb, vecs[v].exp_b);
        end

        // Overrun: repeated FILTER during a run, dropped coefficient write.
        load_coefs(ramp);
        shift_byte(8'hFF);
        filter = 1'b1; tick(); filter = 1'b0;
        strobes = 0;
        for (int c = 1; c <= 12; c++) begin
            filter    = (c == 3) || (c == 8);
            coef_we   = (c == 2);
            coef_addr = 3'd0;
            coef_data = 8'sd100;
            tick();
            filter  = 1'b0;
            coef_we = 1'b0;
            if (c == 2) check("ovr_before", int'(overrun_u), 0);
            if (c == 3) check("ovr_set", int'(overrun_u), 1);
            if (result_valid_u) begin
                strobes++;
                check("ovr_strobe_edge", c, 8);
                check("ovr_result", int'(result_u), 36);
            end
        end
        check("ovr_strobes", strobes, 1);
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
        check("ovr_clr", int'(overrun_u), 0);

        // FILTER on the final RUN edge still flags overrun; coef write was dropped.
        filter = 1'b1; tick(); filter = 1'b0;
        strobes = 0;
        for (int c = 1; c <= 10; c++) begin
            filter = (c == 8);
            tick();
            filter = 1'b0;
            if (result_valid_u) begin
                strobes++;
                check("last_edge_result", int'(result_u), 36);
            end
            if (c == 8) check("last_edge_ovr", int'(overrun_u), 1);
        end
        check("last_edge_strobes", strobes, 1);

        // Set wins over clear on the same edge.
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
        filter = 1'b1; tick(); filter = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            filter      = (c == 2) || (c == 4);
            overrun_clr = (c == 4) || (c == 5);
            tick();
            filter      = 1'b0;
            overrun_clr = 1'b0;
            if (c == 4) check("set_wins", int'(overrun_u), 1);
            if (c == 5) check("clr_after", int'(overrun_u), 0);
        end

        // Shift and accept on the same edge: snapshot takes the pre-shift buffer.
        shift_byte(8'h00);
        bit_valid = 1'b1; bit_in = 1'b1; filter = 1'b1;
        tick();
        bit_valid = 1'b0; bit_in = 1'b0; filter = 1'b0;
        wait_result("simul", ru, rb);
        check("simul_uni", ru, 0);
        check("simul_bip", rb, -36);
        run_filter("simul2", ru, rb);
        check("simul2_uni", ru, 1);
        check("simul2_bip", rb, -34);

        // Asynchronous reset mid-cycle clears outputs immediately.
        #3 rst_n = 1'b0;
        #1;
        check("arst_result", int'(result_u), 0);
        check("arst_result_b", int'(result_b), 0);
        check("arst_busy", int'(busy_u), 0);
        #2 rst_n = 1'b1;
        tick();
        shift_byte(8'hFF);
        run_filter("zero_coef", ru, rb);
        check("zero_coef_uni", ru, 0);

        // Abort a run with reset at k+3.
        load_coefs(pk(-128, -128, -128, -128, -128, -128, -128, -128));
        shift_byte(8'hFF);
        run_filter("pre_abort", ru, rb);
        check("pre_abort_uni", ru, -1024);
        filter = 1'b1; tick(); filter = 1'b0;
        tick(); tick();
        #3 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy_u), 0);
        check("abort_result", int'(result_u), 0);
        check("abort_valid", int'(result_valid_u), 0);
        tick(); tick();
        rst_n = 1'b1;
        strobes = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (result_valid_u) strobes++;
        end
        check("abort_no_strobe", strobes, 0);
        shift_byte(8'hFF);
        run_filter("post_abort", ru, rb);
        check("post_abort_coefs_zero", ru, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
